mask_frame_streamer: RTL and testbench
======================================

// Module: mask_frame_streamer
// PURPOSE
//  Produces the per-frame binary-mask pixel stream that the connected-component labeller consumes.
//  Takes the full-resolution camera mask stream and decimates it to WIDTH x HEIGHT.
//  Captures one decimated frame into an on-chip 1-bit frame buffer.
//  When the labeller is not busy, pulses new_frame_out, then replays the frame at one pixel per clock
//  in raster order, ending at (WIDTH-1, HEIGHT-1).
//  Camera frames that arrive while a frame is pending or streaming are dropped and counted.
// PARAMETERS
//  SRC_WIDTH   1280  camera active columns
//  SRC_HEIGHT  720   camera active rows
//  DECIM       4     decimation factor, power of two; requires SRC_WIDTH/DECIM==WIDTH and SRC_HEIGHT/DECIM==HEIGHT
//  WIDTH       320   output columns
//  HEIGHT      180   output rows
// PORTS
//  clk_in            in   1   single system clock
//  rst_in            in   1   synchronous, active-high reset
//  hcount_in         in   11  camera pixel column
//  vcount_in         in   10  camera pixel row
//  mask_in           in   1   camera pixel mask bit
//  valid_in          in   1   camera pixel qualifier
//  busy_in           in   1   labeller busy; a new frame is not started while high
//  new_frame_out     out  1   one-cycle pulse, exactly 1 cycle before the first valid_out
//  x_out             out  11  output column 0..WIDTH-1
//  y_out             out  10  output row 0..HEIGHT-1
//  mask_out          out  1   mask bit at (x_out, y_out)
//  valid_out         out  1   qualifies x_out/y_out/mask_out
//  busy_out          out  1   high in every state except IDLE and WAIT_SOF
//  frames_dropped    out  16  saturating count of skipped camera frames
// BEHAVIOUR
//  Reset: all outputs are 0; state is IDLE; counters and pipeline registers are cleared.
//    Reset mid-operation aborts capture or stream immediately; no partial stream resumes.
//  SOF is defined as valid_in && hcount_in==0 && vcount_in==0.
//  Keep rule: valid_in && hcount_in<SRC_WIDTH && vcount_in<SRC_HEIGHT
//    && hcount_in[log2(DECIM)-1:0]==0 && vcount_in[log2(DECIM)-1:0]==0.
//  Write address = (vcount_in>>log2 DECIM)*WIDTH + (hcount_in>>log2 DECIM), width $clog2(WIDTH*HEIGHT).
//  States:
//   IDLE: next cycle goes to WAIT_SOF.
//   WAIT_SOF: on SOF, go to CAPTURE; the SOF pixel itself is written to address 0.
//   CAPTURE: write every kept pixel to the buffer.
//     After writing decimated (WIDTH-1, HEIGHT-1), go to WAIT_READY.
//   WAIT_READY: when busy_in==0, assert new_frame_out for 1 cycle, reset rd_addr to 0, go to STREAM.
//   STREAM: issue one read per cycle for rd_addr = 0..WIDTH*HEIGHT-1.
//     Buffer read latency is 2 cycles; the x/y counters are delayed 2 stages to stay aligned with the data.
//     valid_out is high for exactly WIDTH*HEIGHT consecutive cycles.
//     The first valid_out is at (0,0), 1 cycle after new_frame_out; the last is at (WIDTH-1, HEIGHT-1).
//     After the last read is issued, drain the 2-stage pipe, then go to WAIT_SOF.
//  x/y wrap: x increments to WIDTH-1, then returns to 0 and y increments.
//    y stops at HEIGHT-1; there is no wrap past the frame end.
//  Drop rule: an SOF seen in WAIT_READY or STREAM increments frames_dropped, saturating at 16'hFFFF.
//    The SOF seen in WAIT_SOF is not counted.
//  busy_in during STREAM is ignored; once started, a stream always completes.
//  When valid_out==0, x_out, y_out and mask_out are 0.
//  new_frame_out and valid_out are never high in the same cycle.
//  Buffer writes occur only in CAPTURE (plus the WAIT_SOF->CAPTURE SOF pixel); reads occur only in STREAM.
// STRUCTURE
//  Shared package ccl_pkg:
//   WIDTH/HEIGHT defaults.
//   FB_DEPTH = WIDTH*HEIGHT and FB_ADDR_W = $clog2(FB_DEPTH).
//   Coordinate widths: 11 bits for x, 10 bits for y.
//   typedef enum streamer_state_t {IDLE, WAIT_SOF, CAPTURE, WAIT_READY, STREAM}.
//  One sub-module: xilinx_true_dual_port_read_first_2_clock_ram.
//   RAM_WIDTH=1, RAM_DEPTH=FB_DEPTH, both clocks tied to clk_in.
//   Port A is write-only (camera side); port B is read-only (stream side), with regceb tied high for 2-cycle latency.
//  The FSM, decimation and coordinate pipeline are inline.
// TESTING
//  1. Solid frame: camera frame with mask_in=1 everywhere, busy_in=0.
//     -> new_frame_out pulses once.
//     -> 57600 consecutive valid_out cycles, all mask_out=1.
//     -> The last beat is x_out=319, y_out=179.
//  2. Pattern: mask_in=1 only where hcount==vcount (both multiples of 4).
//     -> mask_out=1 only at x==y, for 0..179.
//     -> Every other beat carries 0.
//  3. Busy hold: busy_in=1 for 5000 cycles after capture completes.
//     -> No new_frame_out or valid_out during the hold.
//     -> new_frame_out occurs 1 cycle after busy_in falls.
//     -> A camera SOF during the hold gives frames_dropped=1.
//  4. Back-to-back frames with busy_in=0: one SOF lands mid-STREAM.
//     -> frames_dropped increments by 1.
//     -> The next captured frame starts at the following SOF.
//     -> Stream count is exactly 57600 per frame.
//  5. Reset mid-stream at beat 1000.
//     -> The cycle after reset: all outputs 0, frames_dropped=0.
//     -> No valid_out until a fresh SOF-triggered capture completes.
//  6. Off-grid and invalid pixels: hcount/vcount not multiples of 4, valid_in=0, and hcount>=1280.
//     -> The buffer is unchanged; streamed data matches only the kept pixels.

Source files
------------

// File: rtl/ccl_pkg.sv
// Shared definitions for the connected-component labelling front end:
// default frame geometry, frame-buffer sizing and the streamer state type.
package ccl_pkg;

  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 180;
  localparam int FB_DEPTH   = DEF_WIDTH * DEF_HEIGHT;
  localparam int FB_ADDR_W  = $clog2(FB_DEPTH);

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int DROP_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    WAIT_READY,
    STREAM
  } streamer_state_t;

endpackage

// File: rtl/mask_frame_streamer_if.sv
// Camera-side input stream, labeller handshake and decimated output stream
// of the mask frame streamer.
interface mask_frame_streamer_if;
  import ccl_pkg::*;

  logic [X_W-1:0]    hcount_in;
  logic [Y_W-1:0]    vcount_in;
  logic              mask_in;
  logic              valid_in;
  logic              busy_in;
  logic              new_frame_out;
  logic [X_W-1:0]    x_out;
  logic [Y_W-1:0]    y_out;
  logic              mask_out;
  logic              valid_out;
  logic              busy_out;
  logic [DROP_W-1:0] frames_dropped;

  modport slave (
    input  hcount_in, vcount_in, mask_in, valid_in, busy_in,
    output new_frame_out, x_out, y_out, mask_out, valid_out, busy_out, frames_dropped
  );

  modport master (
    output hcount_in, vcount_in, mask_in, valid_in, busy_in,
    input  new_frame_out, x_out, y_out, mask_out, valid_out, busy_out, frames_dropped
  );
endinterface

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Dual-clock block RAM with a write port A and a registered read port B
// (array read register plus output register: 2-cycle read latency).
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024
) (
  input  logic                         clka,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         wea,
  input  logic                         clkb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic                         enb,
  input  logic                         rstb,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_b;

  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (enb) ram_b <= mem[addrb];
  end

  always_ff @(posedge clkb) begin
    if (rstb)        doutb <= '0;
    else if (regceb) doutb <= ram_b;
  end

endmodule

// File: rtl/mask_frame_streamer.sv
// Decimates the camera mask stream into a 1-bit frame buffer and replays one
// captured frame in raster order whenever the labeller is ready for it.
module mask_frame_streamer
  import ccl_pkg::*;
#(
  parameter int SRC_WIDTH  = 1280,
  parameter int SRC_HEIGHT = 720,
  parameter int DECIM      = 4,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT
) (
  input logic                  clk_in,
  input logic                  rst_in,
  mask_frame_streamer_if.slave bus
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int DSH   = $clog2(DECIM);

  localparam logic [X_W-1:0] SRC_W_L = X_W'(SRC_WIDTH);
  localparam logic [Y_W-1:0] SRC_H_L = Y_W'(SRC_HEIGHT);
  localparam logic [X_W-1:0] DMASK_X = X_W'(DECIM - 1);
  localparam logic [Y_W-1:0] DMASK_Y = Y_W'(DECIM - 1);
  localparam logic [X_W-1:0] X_LAST  = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(HEIGHT - 1);
  localparam logic [AW:0]    RD_END  = (AW+1)'(DEPTH);
  localparam logic [AW:0]    RD_DONE = (AW+1)'(DEPTH + 1);

  streamer_state_t state, state_n;

  logic              sof, keep, frame_end, wr_en;
  logic [X_W-1:0]    hdec;
  logic [Y_W-1:0]    vdec;
  logic [AW-1:0]     wr_addr, rd_issue_addr;
  logic [AW:0]       rd_addr, rd_addr_n;
  logic [X_W-1:0]    x_cnt, x_cnt_n, cur_x, x1, x2;
  logic [Y_W-1:0]    y_cnt, y_cnt_n, cur_y, y1, y2;
  logic              rd_issue, start, v1, v2, nf, rd_data;
  logic [DROP_W-1:0] drops;

  assign sof  = bus.valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);
  assign keep = bus.valid_in && (bus.hcount_in < SRC_W_L) && (bus.vcount_in < SRC_H_L)
             && ((bus.hcount_in & DMASK_X) == '0) && ((bus.vcount_in & DMASK_Y) == '0);
  assign hdec      = bus.hcount_in >> DSH;
  assign vdec      = bus.vcount_in >> DSH;
  assign frame_end = (hdec == X_LAST) && (vdec == Y_LAST);
  assign wr_addr   = AW'(vdec) * AW'(WIDTH) + AW'(hdec);

  // The first read goes out on the WAIT_READY->STREAM transition so that,
  // with the 2-cycle RAM, pixel (0,0) lands one cycle after new_frame_out.
  always_comb begin
    state_n       = state;
    rd_addr_n     = rd_addr;
    x_cnt_n       = x_cnt;
    y_cnt_n       = y_cnt;
    cur_x         = x_cnt;
    cur_y         = y_cnt;
    rd_issue_addr = rd_addr[AW-1:0];
    rd_issue      = 1'b0;
    start         = 1'b0;
    wr_en         = 1'b0;
    case (state)
      IDLE:     state_n = WAIT_SOF;
      WAIT_SOF: if (sof) begin
        wr_en   = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE:  if (keep) begin
        wr_en = 1'b1;
        if (frame_end) state_n = WAIT_READY;
      end
      WAIT_READY: if (!bus.busy_in) begin
        start         = 1'b1;
        rd_issue      = 1'b1;
        cur_x         = '0;
        cur_y         = '0;
        rd_issue_addr = '0;
        rd_addr_n     = (AW+1)'(1);
        state_n       = STREAM;
      end
      STREAM: begin
        if (rd_addr < RD_END) begin
          rd_issue  = 1'b1;
          rd_addr_n = rd_addr + 1'b1;
        end else if (rd_addr == RD_DONE) begin
          state_n = WAIT_SOF;
        end else begin
          rd_addr_n = rd_addr + 1'b1;
        end
      end
      default:  state_n = IDLE;
    endcase
    if (rd_issue) begin
      if (cur_x == X_LAST) begin
        x_cnt_n = '0;
        y_cnt_n = (cur_y == Y_LAST) ? cur_y : cur_y + 1'b1;
      end else begin
        x_cnt_n = cur_x + 1'b1;
        y_cnt_n = cur_y;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      rd_addr <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      x1      <= '0;
      y1      <= '0;
      x2      <= '0;
      y2      <= '0;
      nf      <= 1'b0;
      drops   <= '0;
    end else begin
      state   <= state_n;
      rd_addr <= rd_addr_n;
      x_cnt   <= x_cnt_n;
      y_cnt   <= y_cnt_n;
      v1      <= rd_issue;
      x1      <= rd_issue ? cur_x : '0;
      y1      <= rd_issue ? cur_y : '0;
      v2      <= v1;
      x2      <= x1;
      y2      <= y1;
      nf      <= start;
      if (sof && (state == WAIT_READY || state == STREAM) && drops != '1)
        drops <= drops + 1'b1;
    end
  end

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH(1),
    .RAM_DEPTH(DEPTH)
  ) frame_buf (
    .clka  (clk_in),
    .addra (wr_addr),
    .dina  (bus.mask_in),
    .wea   (wr_en),
    .clkb  (clk_in),
    .addrb (rd_issue_addr),
    .enb   (rd_issue),
    .rstb  (rst_in),
    .regceb(1'b1),
    .doutb (rd_data)
  );

  assign bus.new_frame_out  = nf;
  assign bus.valid_out      = v2;
  assign bus.x_out          = x2;
  assign bus.y_out          = y2;
  assign bus.mask_out       = v2 & rd_data;
  assign bus.busy_out       = !(state == IDLE || state == WAIT_SOF);
  assign bus.frames_dropped = drops;

endmodule

// File: tb/tb_mask_frame_streamer.sv
// Directed bench for mask_frame_streamer on a reduced 64x32 camera / 16x8 output
// geometry, with a decimated-image model and a per-cycle output scoreboard.
module tb_mask_frame_streamer;

  localparam int SW = 64;
  localparam int SH = 32;
  localparam int D  = 4;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int HT = SW + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mask_frame_streamer_if bus();

  mask_frame_streamer #(
    .SRC_WIDTH (SW),
    .SRC_HEIGHT(SH),
    .DECIM     (D),
    .WIDTH     (W),
    .HEIGHT    (H)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int m;
  } beat_t;

  beat_t expq[$];
  int n_checks = 0;
  int n_pass   = 0;
  int beats    = 0;
  int ones     = 0;
  int nf_cnt   = 0;
  int run      = 0;
  int last_x   = 0;
  int last_y   = 0;
  bit prev_nf  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // Camera mask for pattern pat at source pixel (h,v); columns >= SW are blanking junk.
  function automatic int pix(input int pat, input int h, input int v);
    bit on;
    int x, y;
    on = (h % D == 0) && (v % D == 0);
    x  = h / D;
    y  = v / D;
    if (h >= SW) return (pat == 1) ? 0 : 1;
    case (pat)
      0:       return 1;
      1:       return (h == v && on) ? 1 : 0;
      2:       return on ? (((x + 2 * y) % 3 == 0) ? 1 : 0) : 1;
      default: return on ? ((x ^ y) & 1) : ((h + v) & 1);
    endcase
  endfunction

  function automatic int enc(input int x, input int y, input int m);
    return x * 65536 + y * 2 + m;
  endfunction

  task automatic push_frame(input int pat);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        beat_t b;
        b.x = x;
        b.y = y;
        b.m = pix(pat, D * x, D * y);
        expq.push_back(b);
      end
  endtask

  task automatic drive(input int h, input int v, input bit vld, input bit m);
    @(posedge clk);
    #1;
    bus.hcount_in = 11'(h);
    bus.vcount_in = 10'(v);
    bus.valid_in  = vld;
    bus.mask_in   = m;
  endtask

  // noise: after each on-grid pixel, repeat its coordinates with valid_in=0 and the inverted mask
  task automatic send_frame(input int pat, input bit noise, input int rows);
    for (int v = 0; v < rows; v++)
      for (int h = 0; h < HT; h++) begin
        drive(h, v, 1'b1, pix(pat, h, v) != 0);
        if (noise && h < SW && h % D == 0 && v % D == 0)
          drive(h, v, 1'b0, pix(pat, h, v) == 0);
      end
    drive(0, 0, 1'b0, 1'b0);
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 4000 && beats < target; i++) @(posedge clk);
    chk("stream_beats", beats, target);
  endtask

  // Scoreboard: every non-reset cycle is checked against the expected-beat queue.
  initial begin
    forever begin
      beat_t e;
      @(negedge clk);
      if (rst) begin
        run     = 0;
        prev_nf = 1'b0;
      end else begin
        if (prev_nf) chk("nf_then_valid", int'(bus.valid_out), 1);
        if (bus.new_frame_out) begin
          nf_cnt++;
          chk("nf_valid_exclusive", int'(bus.valid_out), 0);
        end
        prev_nf = bus.new_frame_out;
        if (bus.valid_out) begin
          if (expq.size() == 0) begin
            chk("unexpected_beat", int'(bus.valid_out), 0);
          end else begin
            e = expq.pop_front();
            chk("beat_xym", enc(int'(bus.x_out), int'(bus.y_out), int'(bus.mask_out)),
                enc(e.x, e.y, e.m));
          end
          beats++;
          run++;
          if (bus.mask_out) ones++;
          last_x = int'(bus.x_out);
          last_y = int'(bus.y_out);
        end else begin
          if (run != 0) chk("run_length", run, N);
          run = 0;
          chk("idle_outputs_zero", enc(int'(bus.x_out), int'(bus.y_out), int'(bus.mask_out)), 0);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, b1, n0, o0;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.mask_in   = 1'b0;
    bus.valid_in  = 1'b0;
    bus.busy_in   = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_new_frame", int'(bus.new_frame_out), 0);
    chk("rst_valid", int'(bus.valid_out), 0);
    chk("rst_xym", enc(int'(bus.x_out), int'(bus.y_out), int'(bus.mask_out)), 0);
    chk("rst_busy_out", int'(bus.busy_out), 0);
    chk("rst_dropped", int'(bus.frames_dropped), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // solid frame
    push_frame(0);
    b0 = beats; n0 = nf_cnt; o0 = ones;
    send_frame(0, 1'b0, SH);
    wait_beats(b0 + N);
    chk("t1_nf_pulses", nf_cnt - n0, 1);
    chk("t1_ones", ones - o0, 128);
    chk("t1_last_x", last_x, 15);
    chk("t1_last_y", last_y, 7);

    // diagonal
    push_frame(1);
    b0 = beats; o0 = ones;
    send_frame(1, 1'b0, SH);
    wait_beats(b0 + N);
    chk("t2_diag_ones", ones - o0, 8);
    chk("t2_dropped", int'(bus.frames_dropped), 0);

    // busy hold with a camera frame arriving during the hold
    push_frame(3);
    b0 = beats; n0 = nf_cnt;
    bus.busy_in = 1'b1;
    send_frame(3, 1'b0, SH);
    chk("t3_busy_out_pending", int'(bus.busy_out), 1);
    send_frame(0, 1'b0, SH);
    repeat (2500) @(posedge clk);
    chk("t3_no_nf_in_hold", nf_cnt - n0, 0);
    chk("t3_no_beats_in_hold", beats - b0, 0);
    chk("t3_dropped", int'(bus.frames_dropped), 1);
    @(posedge clk);
    #1 bus.busy_in = 1'b0;
    @(negedge clk);
    chk("t3_nf_same_cycle", int'(bus.new_frame_out), 0);
    @(negedge clk);
    chk("t3_nf_next_cycle", int'(bus.new_frame_out), 1);
    wait_beats(b0 + N);

    // back-to-back: short frame A, frame B's SOF lands mid-stream, frame C captured
    push_frame(2);
    push_frame(1);
    b0 = beats; n0 = nf_cnt;
    send_frame(2, 1'b1, 29);
    send_frame(0, 1'b0, SH);
    send_frame(1, 1'b0, SH);
    wait_beats(b0 + 2 * N);
    chk("t4_dropped", int'(bus.frames_dropped), 2);
    chk("t4_nf_pulses", nf_cnt - n0, 2);

    // reset in the middle of a stream
    push_frame(3);
    b0 = beats;
    b1 = beats;
    fork
      send_frame(3, 1'b0, SH);
      begin
        for (int i = 0; i < 4000 && beats < b0 + 60; i++) @(posedge clk);
        chk("t5_reached_beat_60", int'(beats >= b0 + 60), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", int'(bus.valid_out), 0);
        chk("t5_new_frame", int'(bus.new_frame_out), 0);
        chk("t5_xym", enc(int'(bus.x_out), int'(bus.y_out), int'(bus.mask_out)), 0);
        chk("t5_busy_out", int'(bus.busy_out), 0);
        chk("t5_dropped", int'(bus.frames_dropped), 0);
        expq.delete();
        b1 = beats;
      end
    join
    chk("t5_no_resume", beats - b1, 0);

    // fresh capture with off-grid, invalid and blanking pixels
    push_frame(2);
    send_frame(2, 1'b1, SH);
    wait_beats(b1 + N);
    repeat (10) @(posedge clk);
    chk("final_queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
